or_8_way: RTL and testbench



---
 rtl/gates_pkg.sv | 7 +
 rtl/or_8_way_or2_gate.sv | 8 +
 rtl/or_8_way.sv | 82 ++++++++
 tb/tb_or_8_way.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gates_pkg.sv
// Shared constants and types for the gate library.
package gates_pkg;
   localparam int unsigned OR8_WIDTH = 8;
   localparam int unsigned OR8_IDX_W = 3;

   typedef logic [7:0] byte_t;
endpackage

// File: rtl/or_8_way_or2_gate.sv
// Two-input OR gate; leaf cell of the or_8_way reduction tree.
module or2_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i | b_i;
endmodule

// File: rtl/or_8_way.sv
// Eight-input OR reduction with registered copy, lowest-set-bit index and optional
// sticky flag. Define OR_8_WAY_STICKY_EN to build the sticky register and clr logic.
module or_8_way
   import gates_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in,
   input  logic                 clr,
   output logic                 out,
   output logic                 out_q,
   output logic [OR8_IDX_W-1:0] idx,
   output logic                 sticky
);

   if (WIDTH != OR8_WIDTH) begin : g_bad_width
      $error("or_8_way: WIDTH must be 8");
   end

   logic [3:0] lvl1;
   logic [1:0] lvl2;

   for (genvar g = 0; g < 4; g++) begin : g_lvl1
      or2_gate u_or (.a_i(in[2*g]), .b_i(in[2*g+1]), .y_o(lvl1[g]));
   end

   for (genvar g = 0; g < 2; g++) begin : g_lvl2
      or2_gate u_or (.a_i(lvl1[2*g]), .b_i(lvl1[2*g+1]), .y_o(lvl2[g]));
   end

   or2_gate u_or_root (.a_i(lvl2[0]), .b_i(lvl2[1]), .y_o(out));

   // Bit 0 has highest priority; idx stays 0 when no bit is set.
   always_comb begin
      logic found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < OR8_WIDTH; i++) begin
         if (in[i] && !found) begin
            idx   = OR8_IDX_W'(i);
            found = 1'b1;
         end
      end
   end

   logic out_r_q;
   logic out_r_d;

   assign out_r_d = out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) out_r_q <= 1'b0;
      else       out_r_q <= out_r_d;
   end

   assign out_q = out_r_q;

`ifdef OR_8_WAY_STICKY_EN
   logic sticky_q;
   logic sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      if (clr)      sticky_d = 1'b0;
      else if (out) sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sticky_q <= 1'b0;
      else       sticky_q <= sticky_d;
   end

   assign sticky = sticky_q;
`else
   logic unused_clr;
   assign unused_clr = clr;
   assign sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_or_8_way.sv
// Directed self-checking bench for or_8_way (honours OR_8_WAY_STICKY_EN).
module tb_or_8_way;
   import gates_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   byte_t       in;
   logic        clr;
   logic        out;
   logic        out_q;
   logic [2:0]  idx;
   logic        sticky;

   int n_checks = 0;
   int n_fail   = 0;

   or_8_way #(.WIDTH(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .in     (in),
      .clr    (clr),
      .out    (out),
      .out_q  (out_q),
      .idx    (idx),
      .sticky (sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      byte_t      vin;
      logic       exp_out;
      logic [2:0] exp_idx;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{8'b0000_0000, 1'b0, 3'd0};
      vecs[1]  = '{8'b0000_0001, 1'b1, 3'd0};
      vecs[2]  = '{8'b0001_0000, 1'b1, 3'd4};
      vecs[3]  = '{8'b1000_0000, 1'b1, 3'd7};
      vecs[4]  = '{8'b1010_1010, 1'b1, 3'd1};
      vecs[5]  = '{8'b1111_1111, 1'b1, 3'd0};
      vecs[6]  = '{8'b0000_0000, 1'b0, 3'd0};
      vecs[7]  = '{8'b0000_1100, 1'b1, 3'd2};
      vecs[8]  = '{8'b0100_0000, 1'b1, 3'd6};
      vecs[9]  = '{8'b0110_0000, 1'b1, 3'd5};
      vecs[10] = '{8'b0000_1000, 1'b1, 3'd3};
      vecs[11] = '{8'b0000_0010, 1'b1, 3'd1};
      vecs[12] = '{8'b1100_0100, 1'b1, 3'd2};
      vecs[13] = '{8'b0000_0000, 1'b0, 3'd0};

      reset = 1'b1;
      clr   = 1'b0;
      in    = 8'h00;
      #2;
      check("reset_out_q", {7'b0, out_q}, 8'h0);
      check("reset_sticky", {7'b0, sticky}, 8'h0);
      // combinational outputs follow in while reset is held
      in = 8'h20;
      #1;
      check("reset_out_follows", {7'b0, out}, 8'h1);
      check("reset_idx_follows", {5'b0, idx}, 8'h5);
      in = 8'h00;
      @(negedge clk);
      reset = 1'b0;

      // table: combinational result before the edge, registered copy after it
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         in = vecs[i].vin;
         #1;
         check($sformatf("out[%0d]", i), {7'b0, out}, {7'b0, vecs[i].exp_out});
         check($sformatf("idx[%0d]", i), {5'b0, idx}, {5'b0, vecs[i].exp_idx});
         @(posedge clk);
         #1;
         check($sformatf("out_q[%0d]", i), {7'b0, out_q}, {7'b0, vecs[i].exp_out});
      end

      // X handling: a known 1 dominates, an X alone propagates
      @(negedge clk);
      in = 8'b1000_000x;
      #1;
      check("x_with_one", {7'b0, out}, 8'h1);
      in = 8'b0000_000x;
      #1;
      check("x_alone", {7'b0, out}, 8'bxxxx_xxxx & 8'h01);
      in = 8'h00;

`ifdef OR_8_WAY_STICKY_EN
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("sticky_zero[%0d]", i), {7'b0, sticky}, 8'h0);
      end
      @(negedge clk);
      in = 8'h10;
      #1;
      check("sticky_before_edge", {7'b0, sticky}, 8'h0);
      @(posedge clk);
      #1;
      check("sticky_set", {7'b0, sticky}, 8'h1);
      @(negedge clk);
      in = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("sticky_hold[%0d]", i), {7'b0, sticky}, 8'h1);
      end
      @(negedge clk);
      in  = 8'hFF;
      clr = 1'b1;
      @(posedge clk);
      #1;
      check("sticky_clr_priority", {7'b0, sticky}, 8'h0);
      @(negedge clk);
      clr = 1'b0;
      @(posedge clk);
      #1;
      check("sticky_reset_after_clr", {7'b0, sticky}, 8'h1);
`else
      @(negedge clk);
      in  = 8'hFF;
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("nosticky_sticky[%0d]", i), {7'b0, sticky}, 8'h0);
         check($sformatf("nosticky_out_q[%0d]", i), {7'b0, out_q}, 8'h1);
      end
      clr = 1'b0;
`endif

      // async reset between edges while registered state is set
      @(negedge clk);
      in = 8'hFF;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_async_out_q", {7'b0, out_q}, 8'h1);
`ifdef OR_8_WAY_STICKY_EN
      check("pre_async_sticky", {7'b0, sticky}, 8'h1);
`endif
      #2;
      reset = 1'b1;
      #1;
      check("async_out_q", {7'b0, out_q}, 8'h0);
      check("async_sticky", {7'b0, sticky}, 8'h0);
      check("async_out", {7'b0, out}, 8'h1);
      check("async_idx", {5'b0, idx}, 8'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_out_q", {7'b0, out_q}, 8'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
